// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-serial unified-RAM controller: FSM states,
// access-length codes, requester ownership and a length normaliser.
package mem_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // The code value doubles as the byte count of the access.
  typedef enum logic [2:0] {
    LEN_B = 3'd1,
    LEN_H = 3'd2,
    LEN_W = 3'd4
  } len_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  function automatic len_t norm_len(input logic [2:0] raw);
    case (raw)
      3'd1:    return LEN_B;
      3'd2:    return LEN_H;
      default: return LEN_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester and RAM-side signals of the memory controller; the controller
// uses the slave modport, the pipeline/RAM environment the master modport.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;

  logic              mem_load;
  logic              mem_save;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [2:0]        mem_len;
  logic              mem_signed;
  logic              mem_done;
  logic [31:0]       mem_rdata;

  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  modport slave (
    input  if_req, if_addr, mem_load, mem_save, mem_addr, mem_wdata,
           mem_len, mem_signed, ram_din,
    output if_done, if_data, mem_done, mem_rdata, ram_a, ram_wr, ram_dout
  );

  modport master (
    output if_req, if_addr, mem_load, mem_save, mem_addr, mem_wdata,
           mem_len, mem_signed, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, ram_a, ram_wr, ram_dout
  );

endinterface

// File: rtl/mem_ctrl_extend.sv
// Combinational sign/zero extension of an assembled little-endian load word.
module mem_ctrl_extend
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  len_t        len,
  input  logic        sgn,
  output logic [31:0] word
);

  always_comb begin
    word = raw;
    case (len)
      LEN_B:   word = {{24{sgn & raw[7]}}, raw[7:0]};
      LEN_H:   word = {{16{sgn & raw[15]}}, raw[15:0]};
      default: word = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates the byte-wide unified RAM between instruction fetch and the MEM
// stage, serialising 1/2/4-byte accesses into consecutive byte transfers.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic        clk,
  input logic        rst,
  mem_ctrl_if.slave  bus
);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  len_t              len_q, len_d;
  logic              sgn_q, sgn_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic              ram_wr_q, ram_wr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic [2:0]        len_n;
  logic [2:0]        cnt_nxt;
  logic [1:0]        cap_idx;
  logic [31:0]       asm_word;
  logic [31:0]       ext_word;
  logic [ADDR_W-1:0] req_addr;

  assign len_n   = len_q;
  assign cnt_nxt = cnt_q + 3'd1;
  assign cap_idx = 2'(cnt_q - 3'd1);

  // cnt_q is the index of the byte on ram_a; read data lags it by one cycle.
  always_comb begin
    asm_word = data_q;
    if (state_q == ST_READ && cnt_q != 3'd0) begin
      asm_word[{cap_idx, 3'b000} +: 8] = bus.ram_din;
    end
  end

  mem_ctrl_extend u_extend (
    .raw  (asm_word),
    .len  (len_q),
    .sgn  (sgn_q),
    .word (ext_word)
  );

  assign req_addr = (bus.mem_load || bus.mem_save) ? bus.mem_addr : bus.if_addr;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    len_d       = len_q;
    sgn_d       = sgn_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    ram_a_d     = ram_a_q;
    ram_wr_d    = 1'b0;
    ram_dout_d  = ram_dout_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.mem_load || bus.mem_save || bus.if_req) begin
          addr_d  = req_addr;
          ram_a_d = req_addr;
          cnt_d   = 3'd0;
          data_d  = '0;
          if (bus.mem_load) begin
            owner_d = OWN_MEM;
            len_d   = norm_len(bus.mem_len);
            sgn_d   = bus.mem_signed;
            state_d = ST_READ;
          end else if (bus.mem_save) begin
            owner_d    = OWN_MEM;
            len_d      = norm_len(bus.mem_len);
            sgn_d      = 1'b0;
            wdata_d    = bus.mem_wdata;
            ram_wr_d   = 1'b1;
            ram_dout_d = bus.mem_wdata[7:0];
            state_d    = ST_WRITE;
          end else begin
            owner_d = OWN_IF;
            len_d   = LEN_W;
            sgn_d   = 1'b0;
            state_d = ST_READ;
          end
        end
      end

      ST_READ: begin
        data_d = asm_word;
        if (cnt_q == len_n) begin
          if (owner_q == OWN_IF) if_data_d = ext_word;
          else                   mem_rdata_d = ext_word;
          state_d = ST_DONE;
        end else begin
          if (cnt_nxt < len_n) ram_a_d = addr_q + ADDR_W'(cnt_nxt);
          cnt_d = cnt_nxt;
        end
      end

      ST_WRITE: begin
        if (cnt_nxt < len_n) begin
          ram_a_d    = addr_q + ADDR_W'(cnt_nxt);
          ram_wr_d   = 1'b1;
          ram_dout_d = wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
          cnt_d      = cnt_nxt;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      len_q       <= LEN_B;
      sgn_q       <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      len_q       <= len_d;
      sgn_q       <= sgn_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      ram_a_q     <= ram_a_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus.if_done   = (state_q == ST_DONE) && (owner_q == OWN_IF);
  assign bus.mem_done  = (state_q == ST_DONE) && (owner_q == OWN_MEM);
  assign bus.if_data   = if_data_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.ram_a     = ram_a_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_dout  = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a registered-read byte RAM
// model; each scenario task compares traced bus activity to fixed values.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [0:65535];
  logic        poke_en = 1'b0;
  logic [15:0] poke_a  = '0;
  logic [7:0]  poke_d  = '0;

  always @(posedge clk) begin
    bus.ram_din <= ram[bus.ram_a[15:0]];
    if (poke_en)         ram[poke_a] <= poke_d;
    else if (bus.ram_wr) ram[bus.ram_a[15:0]] <= bus.ram_dout;
  end

  int errors = 0;
  int checks = 0;

  logic [31:0] tr_a    [0:16];
  logic        tr_wr   [0:16];
  logic [7:0]  tr_dout [0:16];
  logic        tr_ifd  [0:16];
  logic        tr_memd [0:16];

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    poke_a = a; poke_d = d; poke_en = 1'b1;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic clear_reqs();
    bus.if_req = 1'b0; bus.mem_load = 1'b0; bus.mem_save = 1'b0;
  endtask

  // Follows one access from its sampling edge; C(c) is recorded at index c.
  task automatic trace(output int done_cyc);
    done_cyc = 0;
    for (int c = 0; c <= 16; c++) begin
      tr_a[c] = '0; tr_wr[c] = 1'b0; tr_dout[c] = '0;
      tr_ifd[c] = 1'b0; tr_memd[c] = 1'b0;
    end
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      tr_a[c] = bus.ram_a; tr_wr[c] = bus.ram_wr; tr_dout[c] = bus.ram_dout;
      tr_ifd[c] = bus.if_done; tr_memd[c] = bus.mem_done;
      if (bus.if_done || bus.mem_done) begin
        done_cyc = c;
        break;
      end
    end
    @(posedge clk); #1;
    if (done_cyc == 0) clear_reqs();
    else if (tr_memd[done_cyc]) begin bus.mem_load = 1'b0; bus.mem_save = 1'b0; end
    else bus.if_req = 1'b0;
  endtask

  task automatic issue_mem(input bit ld, input logic [31:0] a, input logic [2:0] len,
                           input bit sgn, input logic [31:0] wd);
    @(posedge clk); #1;
    bus.mem_addr = a; bus.mem_len = len; bus.mem_signed = sgn; bus.mem_wdata = wd;
    if (ld) bus.mem_load = 1'b1;
    else    bus.mem_save = 1'b1;
  endtask

  task automatic test_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    bus.mem_load = 1'b1; bus.mem_save = 1'b0; bus.mem_addr = 32'h20;
    bus.mem_wdata = 32'h0; bus.mem_len = 3'd4; bus.mem_signed = 1'b1;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++;
    if ({bus.ram_a, bus.ram_wr, bus.ram_dout} !== 41'h0) begin
      errors++; $display("FAIL reset_ram: got a=%h wr=%b dout=%h required 0", bus.ram_a, bus.ram_wr, bus.ram_dout);
    end
    checks++;
    if ({bus.if_done, bus.mem_done} !== 2'b00) begin
      errors++; $display("FAIL reset_done: got if=%b mem=%b required 0", bus.if_done, bus.mem_done);
    end
    checks++;
    if ({bus.if_data, bus.mem_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_data: got if=%h mem=%h required 0", bus.if_data, bus.mem_rdata);
    end
    clear_reqs();
    poke(16'h1000, 8'h13); poke(16'h1001, 8'h05); poke(16'h1002, 8'h10); poke(16'h1003, 8'h00);
    poke(16'h0020, 8'h80); poke(16'h0040, 8'h34); poke(16'h0041, 8'h92);
    poke(16'hFFFF, 8'hAA); poke(16'h0000, 8'h55); poke(16'h0105, 8'h5A);
    poke(16'h0200, 8'h11); poke(16'h0201, 8'h22); poke(16'h0202, 8'h33); poke(16'h0203, 8'h44);
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    int d;
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    trace(d);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tr_a[i+1] !== 32'h1000 + 32'(i) || tr_wr[i+1] !== 1'b0) begin
        errors++; $display("FAIL fetch_addr C%0d: got a=%h wr=%b required a=%h wr=0", i+1, tr_a[i+1], tr_wr[i+1], 32'h1000 + 32'(i));
      end
    end
    checks++;
    if (d !== 6 || tr_ifd[d] !== 1'b1) begin
      errors++; $display("FAIL fetch_done: got cycle %0d required 6 (if_done)", d);
    end
    checks++;
    if (bus.if_data !== 32'h00100513) begin
      errors++; $display("FAIL fetch_data: got %h required 00100513", bus.if_data);
    end
    @(negedge clk);
    checks++;
    if (bus.if_done !== 1'b0 || bus.if_data !== 32'h00100513) begin
      errors++; $display("FAIL fetch_pulse: got done=%b data=%h required 0/00100513", bus.if_done, bus.if_data);
    end
  endtask

  task automatic test_loads();
    int d;
    logic [31:0] exp_data [0:5];
    int          exp_done [0:5];
    logic [31:0] addrs    [0:5];
    logic [2:0]  lens     [0:5];
    bit          sgns     [0:5];
    addrs = '{32'h20, 32'h20, 32'h40, 32'h40, 32'h1000, 32'hFFFF_FFFF};
    lens  = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd0, 3'd2};
    sgns  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_data = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_9234, 32'h0000_9234,
                 32'h0010_0513, 32'h0000_55AA};
    exp_done = '{3, 3, 4, 4, 6, 4};
    for (int t = 0; t < 6; t++) begin
      issue_mem(1'b1, addrs[t], lens[t], sgns[t], 32'h0);
      trace(d);
      checks++;
      if (d !== exp_done[t] || tr_memd[d] !== 1'b1 || tr_ifd[d] !== 1'b0) begin
        errors++; $display("FAIL load%0d_done: got cycle %0d required %0d", t, d, exp_done[t]);
      end
      checks++;
      if (bus.mem_rdata !== exp_data[t]) begin
        errors++; $display("FAIL load%0d_data: got %h required %h", t, bus.mem_rdata, exp_data[t]);
      end
    end
    checks++;
    if (tr_a[1] !== 32'hFFFF_FFFF || tr_a[2] !== 32'h0) begin
      errors++; $display("FAIL load_wrap: got %h,%h required ffffffff,00000000", tr_a[1], tr_a[2]);
    end
    checks++;
    if (bus.if_data !== 32'h00100513) begin
      errors++; $display("FAIL if_data_hold: got %h required 00100513", bus.if_data);
    end
  endtask

  task automatic test_store();
    int d;
    logic [7:0] exp_b [0:3];
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    issue_mem(1'b0, 32'h100, 3'd4, 1'b0, 32'hDEAD_BEEF);
    trace(d);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tr_wr[i+1] !== 1'b1 || tr_a[i+1] !== 32'h100 + 32'(i) || tr_dout[i+1] !== exp_b[i]) begin
        errors++; $display("FAIL sw_byte C%0d: got wr=%b a=%h d=%h required 1/%h/%h", i+1, tr_wr[i+1], tr_a[i+1], tr_dout[i+1], 32'h100 + 32'(i), exp_b[i]);
      end
    end
    checks++;
    if (d !== 5 || tr_memd[d] !== 1'b1 || tr_wr[5] !== 1'b0) begin
      errors++; $display("FAIL sw_done: got cycle %0d wr=%b required 5 wr=0", d, tr_wr[5]);
    end
    issue_mem(1'b0, 32'h104, 3'd1, 1'b0, 32'h1234_5677);
    trace(d);
    checks++;
    if (d !== 2 || ram[16'h104] !== 8'h77 || ram[16'h105] !== 8'h5A) begin
      errors++; $display("FAIL sb: got cycle %0d ram=%h,%h required 2 77,5a", d, ram[16'h104], ram[16'h105]);
    end
    issue_mem(1'b1, 32'h100, 3'd4, 1'b0, 32'h0);
    trace(d);
    checks++;
    if (bus.mem_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL sw_readback: got %h required deadbeef", bus.mem_rdata);
    end
  endtask

  task automatic test_conflict();
    int d;
    bit saw_if;
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    bus.mem_load = 1'b1; bus.mem_addr = 32'h20; bus.mem_len = 3'd1; bus.mem_signed = 1'b1;
    trace(d);
    saw_if = 1'b0;
    for (int c = 1; c <= 12; c++) saw_if |= tr_ifd[c];
    checks++;
    if (d !== 3 || tr_memd[d] !== 1'b1 || saw_if || bus.mem_rdata !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL conflict_mem: got cycle %0d if_done_seen=%b data=%h required 3 0 ffffff80", d, saw_if, bus.mem_rdata);
    end
    trace(d);
    checks++;
    if (d !== 6 || tr_ifd[d] !== 1'b1 || tr_a[1] !== 32'h1000 || bus.if_data !== 32'h00100513) begin
      errors++; $display("FAIL conflict_if: got cycle %0d a=%h data=%h required 6 1000 00100513", d, tr_a[1], bus.if_data);
    end
  endtask

  task automatic test_abort();
    int d;
    issue_mem(1'b1, 32'h100, 3'd4, 1'b0, 32'h0);
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_done !== 1'b0) begin
        errors++; $display("FAIL abort_early C%0d: got mem_done=%b required 0", c, bus.mem_done);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    bus.mem_load = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.ram_a, bus.ram_wr, bus.ram_dout, bus.if_done, bus.mem_done,
         bus.if_data, bus.mem_rdata} !== 107'h0) begin
      errors++; $display("FAIL abort_outs: got a=%h wr=%b d=%h done=%b%b if=%h mem=%h required 0",
                         bus.ram_a, bus.ram_wr, bus.ram_dout, bus.if_done, bus.mem_done, bus.if_data, bus.mem_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    issue_mem(1'b1, 32'h200, 3'd4, 1'b0, 32'h0);
    trace(d);
    checks++;
    if (d !== 6 || bus.mem_rdata !== 32'h4433_2211) begin
      errors++; $display("FAIL abort_fresh: got cycle %0d data=%h required 6 44332211", d, bus.mem_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_loads();
    test_store();
    test_conflict();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Arbitrates the single byte-wide unified RAM between instruction fetch (IF) and the MEM stage, and sequences each 1/2/4-byte access as consecutive byte transfers. Assembles little-endian read data, applies sign/zero extension, and returns a one-cycle done pulse to the winning requester. Sits between the pipeline stages and the RAM port.

Parameters:
ADDR_W, 32, width of all byte addresses (requester and RAM side)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  IF fetch request (always 4-byte read), level, held until if_done
if_addr  in  ADDR_W  fetch byte address
if_done  out  1  one-cycle pulse: if_data valid
if_data  out  32  fetched word; holds until next IF completion
mem_load  in  1  MEM load request, level
mem_save  in  1  MEM store request, level
mem_addr  in  ADDR_W  load/store byte address
mem_wdata  in  32  store data; low mem_len bytes used
mem_len  in  3  access length in bytes: 1, 2, 4; any other value treated as 4
mem_signed  in  1  load: 1 = sign-extend, 0 = zero-extend
mem_done  out  1  one-cycle pulse: load/store complete
mem_rdata  out  32  extended load data; holds until next load completion
ram_a  out  ADDR_W  RAM byte address (registered)
ram_wr  out  1  1 = write ram_dout at ram_a this cycle (registered)
ram_dout  out  8  RAM write byte (registered)
ram_din  in  8  RAM read byte; valid the cycle after ram_a was presented

Behaviour:
- Reset: all outputs 0; state IDLE; byte counter 0; captured-data register 0.
- States: IDLE, READ, WRITE, DONE.
- IDLE: request sampled at an edge; priority mem_load > mem_save > if_req. The winner's address, length, signedness and wdata are latched; later requester changes are ignored until DONE.
- The cycle after the sampling edge is C1. Load or fetch: ram_a = addr+i, ram_wr = 0 in C(i+1), i = 0..n-1.
- Read data: byte i is captured from ram_din at the end of C(i+2). Byte i goes to bits [8i+7:8i].
- Read completion: the last byte is captured at the end of C(n+1). done and the data output are valid in C(n+2). For a 4-byte access, done is in C6.
- Store: ram_a = addr+i, ram_wr = 1, ram_dout = wdata[8i+7:8i] in C(i+1). done is in C(n+1).
- DONE: the owning done pulse is high for exactly one cycle and ram_wr = 0. The next state is IDLE unconditionally, so the earliest new sample is at the end of the DONE cycle.
- Requester contract: drop or change the request in the cycle after done. A request still asserted is treated as a new access.
- Extension:
  - len 1: bits [31:8] = signed ? bit7 : 0.
  - len 2: bits [31:16] = signed ? bit15 : 0.
  - len 4: mem_signed is ignored.
- IF accesses are always len 4, unsigned.
- ram_a holds its last value when not accessing. ram_wr is 0 outside WRITE.
- Address arithmetic wraps modulo 2^ADDR_W.
- Reset mid-access: abort, with no done pulse and ram_wr low the next cycle. Partially written bytes are not rolled back.
- if_done and mem_done are never high in the same cycle.

Decomposition:
- defines.v holds the state encodings, the length codes (LEN_B = 1, LEN_H = 2, LEN_W = 4) and the existing data/address size macros.
- One combinational sub-module, mem_ctrl_extend, takes assembled bytes, length and signedness and returns the extended 32-bit word.

Test Plan:
- Reset: assert rst for 2 cycles with requests active -> all outputs 0, no done, ram_wr 0.
- Fetch: if_req, if_addr = 0x1000, RAM[0x1000..0x1003] = 13 05 10 00 -> ram_a 0x1000..0x1003 in C1..C4, if_done in C6 only, if_data = 0x00100513.
- Loads:
  - LB signed, RAM[0x20] = 0x80 -> mem_rdata = 0xFFFFFF80, mem_done in C3.
  - LBU -> 0x00000080.
  - LH signed, bytes 34 92 -> 0xFFFF9234, mem_done in C4.
- Store: SW 0xDEADBEEF at 0x100 -> ram_wr = 1 with EF, BE, AD, DE at 0x100..0x103 in C1..C4, mem_done in C5, ram_wr 0 in C5.
- Conflict: if_req and mem_load asserted on the same edge -> MEM is served first, no if_done during it. The IF access starts the cycle after mem_done (only if if_req is still high) and completes normally.
- Abort: rst at end of C3 of a 4-byte load -> no mem_done, all outputs 0 after the edge. A fresh load then completes correctly with fresh data.
